axi_mem_responder: RTL and testbench

- AXI4-Lite-style memory responder (subordinate) that terminates the LSU's data read and write channels in simulation and FPGA bring-up builds.
- Holds a word-addressed RAM. Serves one outstanding read and one outstanding write independently, each after a programmable latency.
- Drives the responder side of the same channels the LSU initiates (AR/R, AW/W/B). Read and write paths run concurrently.

---
 rtl/axi_mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4-Lite-style word-addressed RAM responder: one outstanding read and one outstanding write, each answered after LATENCY cycles.
// Define MEM_RAND_DELAY_EN to add 0..7 cycles of LFSR jitter to every request's latency.
module axi_mem_responder #(
   parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);
   localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W       = $clog2(LATENCY + 8) + 1;
   localparam logic [31:0] SPAN        = 32'd4 << DEPTH_LOG2;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

   logic [31:0]      mem [DEPTH];
   logic [CNT_W-1:0] wait_load;

`ifdef MEM_RAND_DELAY_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q >> 1;
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ 8'hB8;
   end

   always_ff @(posedge clock) begin
      if (reset) lfsr_q <= 8'hA5;
      else       lfsr_q <= lfsr_d;
   end

   assign wait_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);
`else
   assign wait_load = CNT_W'(LATENCY);
`endif

   // ---------------- read path ----------------
   r_state_e         r_state_q, r_state_d;
   logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
   logic [31:0]      raddr_q, rdata_q;
   logic [1:0]       rresp_q;
   logic [31:0]      rd_addr, rd_off;
   logic             rd_in_range, r_enter_resp;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_cnt_q   <= r_cnt_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      r_cnt_d   = r_cnt_q;
      case (r_state_q)
         R_IDLE: if (arvalid) begin
            r_cnt_d   = wait_load;
            r_state_d = (wait_load == '0) ? R_RESP : R_WAIT;
         end
         R_WAIT: begin
            if (r_cnt_q == CNT_W'(1)) r_state_d = R_RESP;
            else                      r_cnt_d   = r_cnt_q - CNT_W'(1);
         end
         R_RESP: if (rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      arready = (r_state_q == R_IDLE);
      rvalid  = (r_state_q == R_RESP);
   end

   // With zero latency the RAM is sampled on the acceptance edge, before raddr_q holds the address.
   assign rd_addr      = (r_state_q == R_IDLE) ? araddr : raddr_q;
   assign rd_off       = rd_addr - ADDR_BASE;
   assign rd_in_range  = rd_off < SPAN;
   assign r_enter_resp = (r_state_d == R_RESP) && (r_state_q != R_RESP);

   always_ff @(posedge clock) begin
      if (reset) begin
         raddr_q <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else begin
         if (arvalid && arready) raddr_q <= araddr;
         if (r_enter_resp) begin
            rdata_q <= rd_in_range ? mem[rd_off[DEPTH_LOG2+1:2]] : '0;
            rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign rdata = rdata_q;
   assign rresp = rresp_q;

   // ---------------- write path ----------------
   w_state_e          w_state_q, w_state_d;
   logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
   logic [31:0]       waddr_q, wdata_q;
   logic [3:0]        wstrb_q;
   logic              aw_held_q, w_held_q;
   logic [1:0]        bresp_q;
   logic              aw_fire, w_fire, aw_have, w_have;
   logic [31:0]       wr_addr, wr_data, wr_off;
   logic [3:0]        wr_strb;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic              wr_in_range, w_enter_resp, w_commit;

   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;
   assign aw_have = aw_held_q || aw_fire;
   assign w_have  = w_held_q || w_fire;

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         w_cnt_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_cnt_q   <= w_cnt_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      w_cnt_d   = w_cnt_q;
      case (w_state_q)
         W_IDLE: if (aw_have && w_have) begin
            w_cnt_d   = wait_load;
            w_state_d = (wait_load == '0) ? W_RESP : W_WAIT;
         end
         W_WAIT: begin
            if (w_cnt_q == CNT_W'(1)) w_state_d = W_RESP;
            else                      w_cnt_d   = w_cnt_q - CNT_W'(1);
         end
         W_RESP: if (bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      awready = (w_state_q == W_IDLE) && !aw_held_q;
      wready  = (w_state_q == W_IDLE) && !w_held_q;
      bvalid  = (w_state_q == W_RESP);
   end

   // Held flags stay set until the B handshake so the commit mux keeps pointing at the registered beats.
   always_ff @(posedge clock) begin
      if (reset) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (w_state_q == W_RESP && bready) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end else begin
            if (aw_fire) aw_held_q <= 1'b1;
            if (w_fire)  w_held_q  <= 1'b1;
         end
         if (aw_fire) waddr_q <= awaddr;
         if (w_fire) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (w_enter_resp) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign wr_addr      = aw_held_q ? waddr_q : awaddr;
   assign wr_data      = w_held_q  ? wdata_q : wdata;
   assign wr_strb      = w_held_q  ? wstrb_q : wstrb;
   assign wr_off       = wr_addr - ADDR_BASE;
   assign wr_in_range  = wr_off < SPAN;
   assign wr_idx       = wr_off[DEPTH_LOG2+1:2];
   assign w_enter_resp = (w_state_d == W_RESP) && (w_state_q != W_RESP);
   assign w_commit     = w_enter_resp && wr_in_range && !reset;

   assign bresp = bresp_q;

   // NOTE: the RAM has no reset; contents survive reset and clearing them would need a multi-cycle sweep.
   always_ff @(posedge clock) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder (default build, LATENCY=2, DEPTH_LOG2=12).
module tb_axi_mem_responder;
   localparam logic [31:0] BASE    = 32'h8000_0000;
   localparam int          LAT     = 2;
   localparam int          TIMEOUT = 40;

   logic        clock, reset;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  rresp, bresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
   rsp_t        rexp_q[$];
   logic [1:0]  bexp_q[$];
   logic [31:0] model_mem [int];
   int          total = 0;
   int          bad   = 0;

   axi_mem_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(12), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   // Reference model: byte-merge into a sparse word store, 16 KiB window above BASE.
   function automatic void push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] off, cur;
      int idx;
      off = addr - BASE;
      if (off < 32'h0000_4000) begin
         idx = int'(off >> 2);
         cur = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
         for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
         model_mem[idx] = cur;
         bexp_q.push_back(2'b00);
      end else begin
         bexp_q.push_back(2'b10);
      end
   endfunction

   function automatic void push_read(input logic [31:0] addr);
      logic [31:0] off;
      rsp_t e;
      off = addr - BASE;
      if (off < 32'h0000_4000) begin
         e.data = model_mem.exists(int'(off >> 2)) ? model_mem[int'(off >> 2)] : 32'h0;
         e.resp = 2'b00;
      end else begin
         e.data = 32'h0;
         e.resp = 2'b10;
      end
      rexp_q.push_back(e);
   endfunction

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp, output int lat);
      int n;
      @(negedge clock);
      araddr = addr; arvalid = 1'b1;
      n = 0;
      while (!arready && n < TIMEOUT) begin @(negedge clock); n++; end
      @(negedge clock);
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < TIMEOUT) begin @(negedge clock); lat++; end
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clock);
      rready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
      int n;
      @(negedge clock);
      awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
      n = 0;
      while (!(awready && wready) && n < TIMEOUT) begin @(negedge clock); n++; end
      @(negedge clock);
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 1;
      while (!bvalid && lat < TIMEOUT) begin @(negedge clock); lat++; end
      resp = bresp;
      bready = 1'b1;
      @(negedge clock);
      bready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      total++; if (rvalid !== 1'b0)   begin $display("FAIL rst_rvalid: got %b want 0", rvalid); bad++; end
      total++; if (bvalid !== 1'b0)   begin $display("FAIL rst_bvalid: got %b want 0", bvalid); bad++; end
      total++; if (arready !== 1'b1)  begin $display("FAIL rst_arready: got %b want 1", arready); bad++; end
      total++; if (awready !== 1'b1)  begin $display("FAIL rst_awready: got %b want 1", awready); bad++; end
      total++; if (wready !== 1'b1)   begin $display("FAIL rst_wready: got %b want 1", wready); bad++; end
      total++; if (rdata !== 32'h0)   begin $display("FAIL rst_rdata: got %h want 0", rdata); bad++; end
      total++; if (rresp !== 2'b00)   begin $display("FAIL rst_rresp: got %b want 00", rresp); bad++; end
      total++; if (bresp !== 2'b00)   begin $display("FAIL rst_bresp: got %b want 00", bresp); bad++; end
   endtask

   // Write then read one address, checking responses and latency against the scoreboard.
   task automatic wr_rd(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [1:0] br, rr, eb;
      logic [31:0] rd;
      int lat;
      rsp_t e;
      push_write(addr, data, strb);
      do_write(addr, data, strb, br, lat);
      eb = bexp_q.pop_front();
      total++; if (br !== eb)       begin $display("FAIL %s_bresp: got %b want %b", tag, br, eb); bad++; end
      total++; if (lat != LAT + 1)  begin $display("FAIL %s_blat: got %0d want %0d", tag, lat, LAT + 1); bad++; end
      push_read(addr);
      do_read(addr, rd, rr, lat);
      e = rexp_q.pop_front();
      total++; if (rd !== e.data)   begin $display("FAIL %s_rdata: got %h want %h", tag, rd, e.data); bad++; end
      total++; if (rr !== e.resp)   begin $display("FAIL %s_rresp: got %b want %b", tag, rr, e.resp); bad++; end
      total++; if (lat != LAT + 1)  begin $display("FAIL %s_rlat: got %0d want %0d", tag, lat, LAT + 1); bad++; end
   endtask

   task automatic test_write_read();
      wr_rd("wr_rd", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
   endtask

   task automatic test_strobe();
      wr_rd("strb_full", 32'h8000_0020, 32'h1122_3344, 4'hF);
      wr_rd("strb_0101", 32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
      wr_rd("strb_none", 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000);
   endtask

   task automatic test_aw_before_w();
      logic [1:0] br, eb, rr;
      logic [31:0] rd;
      int n, lat;
      rsp_t e;
      push_write(32'h8000_0030, 32'h0BAD_F00D, 4'hF);
      @(negedge clock);
      awaddr = 32'h8000_0030; awvalid = 1'b1; wvalid = 1'b0;
      n = 0;
      while (!awready && n < TIMEOUT) begin @(negedge clock); n++; end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         total++; if (awready !== 1'b0) begin $display("FAIL awfirst_awready[%0d]: got %b want 0", i, awready); bad++; end
         total++; if (wready !== 1'b1)  begin $display("FAIL awfirst_wready[%0d]: got %b want 1", i, wready); bad++; end
         total++; if (bvalid !== 1'b0)  begin $display("FAIL awfirst_bvalid[%0d]: got %b want 0", i, bvalid); bad++; end
      end
      wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clock);
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 1;
      while (!bvalid && lat < TIMEOUT) begin @(negedge clock); lat++; end
      br = bresp;
      bready = 1'b1;
      @(negedge clock);
      bready = 1'b0;
      eb = bexp_q.pop_front();
      total++; if (br !== eb)      begin $display("FAIL awfirst_bresp: got %b want %b", br, eb); bad++; end
      total++; if (lat != LAT + 1) begin $display("FAIL awfirst_blat: got %0d want %0d", lat, LAT + 1); bad++; end
      push_read(32'h8000_0030);
      do_read(32'h8000_0030, rd, rr, lat);
      e = rexp_q.pop_front();
      total++; if (rd !== e.data)  begin $display("FAIL awfirst_rdata: got %h want %h", rd, e.data); bad++; end
   endtask

   task automatic test_out_of_range();
      logic [1:0] br, eb, rr;
      logic [31:0] rd;
      int lat;
      rsp_t e;
      wr_rd("oor_pre", 32'h8000_0000, 32'h5555_AAAA, 4'hF);
      push_read(32'h7FFF_FFFC);
      do_read(32'h7FFF_FFFC, rd, rr, lat);
      e = rexp_q.pop_front();
      total++; if (rd !== e.data)  begin $display("FAIL oor_rdata: got %h want %h", rd, e.data); bad++; end
      total++; if (rr !== e.resp)  begin $display("FAIL oor_rresp: got %b want %b", rr, e.resp); bad++; end
      push_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF);
      do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, br, lat);
      eb = bexp_q.pop_front();
      total++; if (br !== eb)      begin $display("FAIL oor_bresp: got %b want %b", br, eb); bad++; end
      push_read(32'h8000_0000);
      do_read(32'h8000_0000, rd, rr, lat);
      e = rexp_q.pop_front();
      total++; if (rd !== e.data)  begin $display("FAIL oor_unchanged: got %h want %h", rd, e.data); bad++; end
   endtask

   task automatic test_backpressure();
      int n, lat;
      rsp_t e1, e2;
      wr_rd("bp_pre", 32'h8000_0040, 32'hCAFE_0001, 4'hF);
      push_read(32'h8000_0040);
      push_read(32'h8000_0010);
      @(negedge clock);
      araddr = 32'h8000_0040; arvalid = 1'b1;
      n = 0;
      while (!arready && n < TIMEOUT) begin @(negedge clock); n++; end
      @(negedge clock);
      araddr = 32'h8000_0010;
      n = 1;
      while (!rvalid && n < TIMEOUT) begin @(negedge clock); n++; end
      total++; if (n != LAT + 1) begin $display("FAIL bp_rlat: got %0d want %0d", n, LAT + 1); bad++; end
      e1 = rexp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         total++; if (rvalid !== 1'b1)   begin $display("FAIL bp_rvalid[%0d]: got %b want 1", i, rvalid); bad++; end
         total++; if (rdata !== e1.data) begin $display("FAIL bp_rdata[%0d]: got %h want %h", i, rdata, e1.data); bad++; end
         total++; if (arready !== 1'b0)  begin $display("FAIL bp_arready[%0d]: got %b want 0", i, arready); bad++; end
         @(negedge clock);
      end
      rready = 1'b1;
      @(negedge clock);
      rready = 1'b0;
      total++; if (rvalid !== 1'b0)  begin $display("FAIL bp_rvalid_drop: got %b want 0", rvalid); bad++; end
      total++; if (arready !== 1'b1) begin $display("FAIL bp_arready_back: got %b want 1", arready); bad++; end
      @(negedge clock);
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < TIMEOUT) begin @(negedge clock); lat++; end
      e2 = rexp_q.pop_front();
      total++; if (rdata !== e2.data) begin $display("FAIL bp_second_rdata: got %h want %h", rdata, e2.data); bad++; end
      total++; if (lat != LAT + 1)    begin $display("FAIL bp_second_rlat: got %0d want %0d", lat, LAT + 1); bad++; end
      rready = 1'b1;
      @(negedge clock);
      rready = 1'b0;
   endtask

   // Read and write to the same word accepted together: the read sees the old value.
   task automatic test_collision();
      int n;
      rsp_t e;
      logic [1:0] eb;
      wr_rd("col_pre", 32'h8000_0070, 32'h0000_1111, 4'hF);
      push_read(32'h8000_0070);
      push_write(32'h8000_0070, 32'h2222_0000, 4'hF);
      @(negedge clock);
      araddr = 32'h8000_0070; arvalid = 1'b1;
      awaddr = 32'h8000_0070; awvalid = 1'b1; wdata = 32'h2222_0000; wstrb = 4'hF; wvalid = 1'b1;
      total++; if (!(arready && awready && wready)) begin $display("FAIL col_ready: got %b%b%b want 111", arready, awready, wready); bad++; end
      @(negedge clock);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      n = 1;
      while (!(rvalid && bvalid) && n < TIMEOUT) begin @(negedge clock); n++; end
      e = rexp_q.pop_front();
      eb = bexp_q.pop_front();
      total++; if (rdata !== e.data) begin $display("FAIL col_old_data: got %h want %h", rdata, e.data); bad++; end
      total++; if (bresp !== eb)     begin $display("FAIL col_bresp: got %b want %b", bresp, eb); bad++; end
      total++; if (n != LAT + 1)     begin $display("FAIL col_lat: got %0d want %0d", n, LAT + 1); bad++; end
      rready = 1'b1; bready = 1'b1;
      @(negedge clock);
      rready = 1'b0; bready = 1'b0;
      wr_rd("col_new", 32'h8000_0074, 32'h3333_4444, 4'hF);
      push_read(32'h8000_0070);
      begin
         logic [31:0] rd; logic [1:0] rr; int lat;
         do_read(32'h8000_0070, rd, rr, lat);
         e = rexp_q.pop_front();
         total++; if (rd !== e.data) begin $display("FAIL col_new_data: got %h want %h", rd, e.data); bad++; end
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd;
      logic [1:0] rr;
      int n, lat;
      rsp_t e;
      wr_rd("abort_pre", 32'h8000_0050, 32'h0123_4567, 4'hF);
      @(negedge clock);
      araddr = 32'h8000_0050; arvalid = 1'b1;
      awaddr = 32'h8000_0050; awvalid = 1'b1; wdata = 32'hFEDC_BA98; wstrb = 4'hF; wvalid = 1'b1;
      n = 0;
      while (!(arready && awready && wready) && n < TIMEOUT) begin @(negedge clock); n++; end
      @(negedge clock);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      total++; if (rvalid !== 1'b0)  begin $display("FAIL abort_rvalid: got %b want 0", rvalid); bad++; end
      total++; if (bvalid !== 1'b0)  begin $display("FAIL abort_bvalid: got %b want 0", bvalid); bad++; end
      total++; if (arready !== 1'b1) begin $display("FAIL abort_arready: got %b want 1", arready); bad++; end
      total++; if (awready !== 1'b1) begin $display("FAIL abort_awready: got %b want 1", awready); bad++; end
      total++; if (wready !== 1'b1)  begin $display("FAIL abort_wready: got %b want 1", wready); bad++; end
      total++; if (rdata !== 32'h0)  begin $display("FAIL abort_rdata: got %h want 0", rdata); bad++; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         total++; if (rvalid || bvalid) begin $display("FAIL abort_quiet[%0d]: got r=%b b=%b want 0 0", i, rvalid, bvalid); bad++; end
      end
      push_read(32'h8000_0050);
      do_read(32'h8000_0050, rd, rr, lat);
      e = rexp_q.pop_front();
      total++; if (rd !== e.data) begin $display("FAIL abort_not_committed: got %h want %h", rd, e.data); bad++; end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, d;
      logic [3:0] s;
      for (int i = 0; i < 8; i++) begin
         a = 32'h8000_0100 + 32'(4 * i);
         wr_rd("b2b_fill", a, $urandom, 4'hF);
      end
      for (int i = 0; i < 8; i++) begin
         a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 7));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         wr_rd("b2b_rand", a, d, s);
      end
   endtask

   initial begin
      reset = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      test_reset();
      test_write_read();
      test_strobe();
      test_aw_before_w();
      test_out_of_range();
      test_backpressure();
      test_collision();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
